// File: rtl/conv2_relu_pool.sv
// rtl/conv2_relu_pool.sv - conv2 output stage: bias, ReLU, 12-bit saturation and 2x2 max-pool.
module conv2_relu_pool #(
    parameter int                 WIDTH  = 8,
    parameter int                 HEIGHT = 8,
    parameter logic signed [13:0] BIAS   = 14'sd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic signed [13:0] conv_in,
    output logic signed [11:0] data_out,
    output logic               valid_out,
    output logic               frame_done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int NB = WIDTH / 2;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [11:0]   pair_q;
    logic [11:0]   rowbuf_q [NB];
    logic [11:0]   data_q;
    logic          valid_q;
    logic          frame_done_q;

    logic [14:0]   sum;
    logic [11:0]   r;
    logic [11:0]   pair_max;
    logic [11:0]   blk_max;
    logic [11:0]   buf_rd;
    logic [BW-1:0] buf_idx;
    logic          col_last;
    logic          row_last;

    // 15 bits hold any 14-bit sample plus 14-bit bias without wrap.
    assign sum = {conv_in[13], conv_in} + {BIAS[13], BIAS};

    always_comb begin
        r = sum[11:0];
        if (sum[14]) begin
            r = 12'd0;
        end else if (|sum[13:11]) begin
            r = 12'd2047;
        end
    end

    assign buf_idx  = BW'(col_q >> 1);
    assign buf_rd   = rowbuf_q[buf_idx];
    assign pair_max = (r > pair_q) ? r : pair_q;
    assign blk_max  = (buf_rd > pair_max) ? buf_rd : pair_max;
    assign col_last = (col_q == CW'(WIDTH - 1));
    assign row_last = (row_q == RW'(HEIGHT - 1));

    always_comb begin
        col_d = col_last ? '0 : col_q + 1'b1;
        row_d = row_q;
        if (col_last) begin
            row_d = row_last ? '0 : row_q + 1'b1;
        end
    end

    // Row buffer needs no reset: an even row always writes an entry before the odd row reads it.
    always_ff @(posedge clk) begin
        if (valid_in && col_q[0] && !row_q[0]) begin
            rowbuf_q[buf_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (valid_in) begin
                col_q <= col_d;
                row_q <= row_d;
                if (!col_q[0]) begin
                    pair_q <= r;
                end else if (row_q[0]) begin
                    data_q       <= blk_max;
                    valid_q      <= 1'b1;
                    frame_done_q <= col_last && row_last;
                end
            end
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign frame_done = frame_done_q;

endmodule
